wb_arbiter: RTL and testbench

//  Writeback stage directly upstream of the register file. Accepts results from
//  NUM_SRC crypto execution units over valid/ready, queues them in a small FIFO,
//  and drives one regfile write per cycle (write_enable/write_addr/write_data).

---
 rtl/coproc_pkg.sv | 15 +
 rtl/wb_fifo.sv | 51 +++++
 rtl/wb_arbiter.sv | 92 +++++++++
 tb/tb_wb_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// coproc_pkg: shared widths and the writeback entry type for the crypto coprocessor.
package coproc_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_ADDR_W-1:0] a);
        return NUM_REGS'(1) << a;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry writeback queue exposing every slot and its occupancy for hazard tracking.
module wb_fifo
    import coproc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                head,
    output wb_entry_t [DEPTH-1:0]    entries,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [DEPTH-1:0]         entry_valid
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr_en, rd_en;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign head  = entries[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (wr_en) begin
                entries[wr_ptr] <= din;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar k = 0; k < DEPTH; k++) begin : g_valid
        logic [AW-1:0] off;
        assign off            = AW'(k) - rd_ptr;
        assign entry_valid[k] = {1'b0, off} < count;
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates NUM_SRC results into a writeback FIFO driving one regfile write per cycle.
// Define WB_RR_ARB_EN for round-robin grant; otherwise fixed priority with source 0 highest.
module wb_arbiter
    import coproc_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [REG_ADDR_W*NUM_SRC-1:0] src_addr,
    input  logic [XLEN*NUM_SRC-1:0]       src_data,
    output logic                          write_enable,
    output logic [REG_ADDR_W-1:0]         write_addr,
    output logic [XLEN-1:0]               write_data,
    output logic [NUM_REGS-1:0]           pending,
    output logic [$clog2(DEPTH):0]        fifo_count
);
    localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    logic [REG_ADDR_W-1:0] a_arr [NUM_SRC];
    logic [XLEN-1:0]       d_arr [NUM_SRC];
    logic [SW-1:0]         sel;
    logic                  any, full, empty, hs, push;
    wb_entry_t             din, head, last;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      entry_valid;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign a_arr[g] = src_addr[REG_ADDR_W*g +: REG_ADDR_W];
        assign d_arr[g] = src_data[XLEN*g +: XLEN];
    end

`ifdef WB_RR_ARB_EN
    logic [SW-1:0] rr_ptr, idx;
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            idx = SW'((int'(rr_ptr) + j) % NUM_SRC);
            if (src_valid[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr <= '0;
        else if (hs) rr_ptr <= SW'((int'(sel) + 1) % NUM_SRC);
    end
`else
    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (src_valid[j]) begin
                sel = SW'(j);
                any = 1'b1;
            end
        end
    end
`endif

    // Ready is withheld during reset so no handshake can complete while state is cleared.
    assign hs        = rst && any && !full;
    assign src_ready = hs ? NUM_SRC'(1) << sel : '0;
    assign push      = hs && a_arr[sel] != '0;
    assign din       = '{addr: a_arr[sel], data: d_arr[sel]};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(!empty), .din(din), .head(head),
        .entries(entries), .count(fifo_count), .full(full), .empty(empty),
        .entry_valid(entry_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last <= '0;
        else if (!empty) last <= head;
    end

    assign write_enable = !empty;
    assign write_addr   = empty ? last.addr : head.addr;
    assign write_data   = empty ? last.data : head.data;

    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++)
            pending = entry_valid[k] ? pending | onehot_reg(entries[k].addr) : pending;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized self-checking bench for wb_arbiter against a queue-based model.
module tb_wb_arbiter;
    localparam int NS = 2;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NS-1:0]    src_valid = '0;
    logic [NS-1:0]    src_ready;
    logic [5*NS-1:0]  src_addr = '0;
    logic [32*NS-1:0] src_data = '0;
    logic             write_enable;
    logic [4:0]       write_addr;
    logic [31:0]      write_data;
    logic [31:0]      pending;
    logic [2:0]       fifo_count;

    int errors = 0;
    int checks = 0;

    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t q[$];
    logic [4:0]  last_a = '0;
    logic [31:0] last_d = '0;
    int rr = 0;
    int g  = -1;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_pend;
    int          e_cnt;
    logic [NS-1:0] e_rdy;

    wb_arbiter #(.NUM_SRC(NS), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
        .src_addr(src_addr), .src_data(src_data), .write_enable(write_enable),
        .write_addr(write_addr), .write_data(write_data), .pending(pending),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function void model_reset();
        q.delete();
        last_a = '0;
        last_d = '0;
        rr = 0;
        g = -1;
    endfunction

    // Expected outputs for the current cycle, from queue contents and the grant rule.
    function void model_expect();
        e_cnt  = q.size();
        e_we   = q.size() > 0;
        e_wa   = e_we ? q[0].a : last_a;
        e_wd   = e_we ? q[0].d : last_d;
        e_pend = '0;
        foreach (q[i]) e_pend[q[i].a] = 1'b1;
        e_rdy = '0;
        g = -1;
        if (rst && q.size() < D) begin
            for (int j = 0; j < NS; j++) begin
`ifdef WB_RR_ARB_EN
                if (g < 0 && src_valid[(rr + j) % NS]) g = (rr + j) % NS;
`else
                if (g < 0 && src_valid[j]) g = j;
`endif
            end
            if (g >= 0) e_rdy[g] = 1'b1;
        end
    endfunction

    function void model_advance();
        logic [4:0] a;
        if (!rst) begin
            model_reset();
            return;
        end
        if (q.size() > 0) begin
            last_a = q[0].a;
            last_d = q[0].d;
            void'(q.pop_front());
        end
        if (g >= 0) begin
            a = src_addr[5*g +: 5];
            if (a != 0) q.push_back('{a, src_data[32*g +: 32]});
            rr = (g + 1) % NS;
        end
    endfunction

    task automatic drive(input logic [NS-1:0] v, input logic [5*NS-1:0] a, input logic [32*NS-1:0] d);
        @(negedge clk);
        src_valid = v;
        src_addr  = a;
        src_data  = d;
        #1;
        model_expect();
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        src_valid = 2'b11;
        src_addr  = {5'd2, 5'd1};
        #3;
        checks += 6;
        if (src_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 00", src_ready); end
        if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", write_enable); end
        if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
        if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        if (write_addr !== '0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", write_addr); end
        if (write_data !== '0) begin errors++; $display("FAIL reset_wdata: got %h want 0", write_data); end
        model_reset();
        @(negedge clk);
        src_valid = '0;
        rst = 1'b1;
    endtask

    task automatic test_single();
        drive(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF});
        checks++;
        if (src_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", src_ready); end
        tick();
        drive(2'b00, '0, '0);
        checks += 5;
        if (write_enable !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", write_enable); end
        if (write_addr !== 5'd5) begin errors++; $display("FAIL single_waddr: got %0d want 5", write_addr); end
        if (write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata: got %h want deadbeef", write_data); end
        if (pending !== 32'h20) begin errors++; $display("FAIL single_pending: got %h want 00000020", pending); end
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        tick();
        drive(2'b00, '0, '0);
        checks += 3;
        if (write_enable !== 1'b0) begin errors++; $display("FAIL single_we_after: got %b want 0", write_enable); end
        if (pending !== '0) begin errors++; $display("FAIL single_pending_after: got %h want 0", pending); end
        if (write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_hold: got %0d/%h want 5/deadbeef", write_addr, write_data);
        end
        tick();
    endtask

    task automatic test_addr0();
        drive(2'b01, '0, {32'h0, 32'h1});
        checks++;
        if (src_ready !== 2'b01) begin errors++; $display("FAIL addr0_ready: got %b want 01", src_ready); end
        tick();
        drive(2'b00, '0, '0);
        checks += 3;
        if (write_enable !== 1'b0) begin errors++; $display("FAIL addr0_we: got %b want 0", write_enable); end
        if (fifo_count !== '0) begin errors++; $display("FAIL addr0_count: got %0d want 0", fifo_count); end
        if (pending[0] !== 1'b0) begin errors++; $display("FAIL addr0_pending: got %b want 0", pending[0]); end
        tick();
    endtask

    task automatic test_contention();
        logic [NS-1:0] prev = '0;
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, {5'd2, 5'd1}, {$urandom, $urandom});
            checks += 3;
            if (src_ready !== e_rdy) begin errors++; $display("FAIL cont_ready[%0d]: got %b want %b", i, src_ready, e_rdy); end
`ifdef WB_RR_ARB_EN
            if (i > 0 && src_ready === prev) begin errors++; $display("FAIL cont_alternate[%0d]: got %b want not %b", i, src_ready, prev); end
`else
            if (src_ready !== 2'b01) begin errors++; $display("FAIL cont_fixed[%0d]: got %b want 01", i, src_ready); end
`endif
            if (write_enable !== e_we || write_addr !== e_wa || write_data !== e_wd) begin
                errors++; $display("FAIL cont_write[%0d]: got %b/%0d/%h want %b/%0d/%h", i, write_enable, write_addr, write_data, e_we, e_wa, e_wd);
            end
            prev = src_ready;
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(NS'($urandom), {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))}, {$urandom, $urandom});
            checks += 7;
            if (src_ready !== e_rdy) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, src_ready, e_rdy); end
            if (write_enable !== e_we) begin errors++; $display("FAIL rnd_we[%0d]: got %b want %b", i, write_enable, e_we); end
            if (write_addr !== e_wa) begin errors++; $display("FAIL rnd_waddr[%0d]: got %0d want %0d", i, write_addr, e_wa); end
            if (write_data !== e_wd) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, write_data, e_wd); end
            if (pending !== e_pend) begin errors++; $display("FAIL rnd_pending[%0d]: got %h want %h", i, pending, e_pend); end
            if (int'(fifo_count) != e_cnt) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, fifo_count, e_cnt); end
            if (fifo_count > 3'(D)) begin errors++; $display("FAIL rnd_overflow[%0d]: got %0d want <=%0d", i, fifo_count, D); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive(2'b01, {5'd0, 5'd9}, {32'h0, 32'h12345678});
        tick();
        drive(2'b10, {5'd10, 5'd0}, {32'hCAFEF00D, 32'h0});
        #2;
        rst = 1'b0;
        #1;
        checks += 4;
        if (write_enable !== 1'b0) begin errors++; $display("FAIL arst_we: got %b want 0", write_enable); end
        if (pending !== '0) begin errors++; $display("FAIL arst_pending: got %h want 0", pending); end
        if (fifo_count !== '0) begin errors++; $display("FAIL arst_count: got %0d want 0", fifo_count); end
        if (src_ready !== '0) begin errors++; $display("FAIL arst_ready: got %b want 00", src_ready); end
        tick();
        @(negedge clk);
        src_valid = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, '0, '0);
            checks += 2;
            if (write_enable !== 1'b0) begin errors++; $display("FAIL arst_after_we[%0d]: got %b want 0", i, write_enable); end
            if (write_addr !== '0 || write_data !== '0) begin
                errors++; $display("FAIL arst_after_wout[%0d]: got %0d/%h want 0/0", i, write_addr, write_data);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_addr0();
        test_contention();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
